// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-side definitions: the NOP bubble encoding, the default reset PC
// and the entry format carried by the instruction queue.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with push, pop, clear and a combinational head read.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         push_in,
  input  logic                         pop_in,
  input  logic                         clear_in,
  input  fetch_entry_t                 wdata_in,
  output fetch_entry_t                 head_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_out  = (r_count == CNT_W'(DEPTH));
  assign empty_out = (r_count == '0);
  assign count_out = r_count;
  assign head_out  = r_mem[r_rd_ptr];
  assign w_push    = push_in && (!full_out || pop_in);
  assign w_pop     = pop_in && !empty_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk_in) begin
    if (w_push && !clear_in) r_mem[r_wr_ptr] <= wdata_in;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with in-order memory responses and a small decode queue.
// Define IFETCH_BUBBLE_CNT_EN to add the bubble_cnt_out counter port.
module ifetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
`ifdef IFETCH_BUBBLE_CNT_EN
  , output logic [31:0] bubble_cnt_out
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_inflight;
  logic             w_full;
  logic             w_empty;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_accept;
  logic             w_resp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;

  // Queued plus in-flight words never exceed DEPTH, so counters cannot wrap.
  assign w_inflight    = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_out  = rst_n_in && !redirect_in && !w_full &&
                         (w_inflight < (CNT_W+1)'(DEPTH));
  assign imem_addr_out = r_fetch_pc;
  assign w_accept      = imem_req_out && imem_ready_in;

  // A response with nothing outstanding predates the last reset and is ignored.
  assign w_resp        = imem_rvalid_in && (r_outstanding != '0);
  assign w_drop        = w_resp && (r_discard != '0);
  assign w_push        = w_resp && !w_drop && !redirect_in;
  assign w_push_entry  = '{pc: r_resp_pc, instr: imem_rdata_in};

  assign instr_valid_out = !w_empty && !redirect_in;
  assign w_pop           = instr_valid_out && !stall_in;
  assign flush_out       = w_empty || redirect_in;
  assign instr_out       = w_empty ? NOP_INSTR : w_head.instr;
  assign pc_out          = w_empty ? r_resp_pc : w_head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (w_push),
    .pop_in    (w_pop),
    .clear_in  (redirect_in),
    .wdata_in  (w_push_entry),
    .head_out  (w_head),
    .full_out  (w_full),
    .empty_out (w_empty),
    .count_out (w_count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fetch_pc    <= word_align(RESET_PC);
      r_resp_pc     <= word_align(RESET_PC);
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_in) begin
      r_fetch_pc    <= word_align(redirect_pc_in);
      r_resp_pc     <= word_align(redirect_pc_in);
      r_outstanding <= r_outstanding - CNT_W'(w_resp);
      r_discard     <= r_outstanding - CNT_W'(w_resp);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)   r_resp_pc  <= r_resp_pc + 32'd4;
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);
      if (w_drop)   r_discard  <= r_discard - 1'b1;
    end
  end

`ifdef IFETCH_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                    r_bubble_cnt <= '0;
    else if (flush_out && !stall_in)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign bubble_cnt_out = r_bubble_cnt;
`endif

endmodule
